// File: rtl/serdes_deser_framed.sv
// serdes_deser_framed
//   Serial-to-parallel receiver with sync-word framing and a small output FIFO.
//   In HUNT it watches a sliding window of received bits for SYNC_WORD. Once
//   locked, it assembles WIDTH-bit words, drops idle-fill sync words, and
//   buffers the rest for a valid/ready consumer.
//
// Ports
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   en          in   1      bit strobe; sin sampled only when en=1
//   sin         in   1      serial data in
//   resync      in   1      pulse: drop lock and return to HUNT
//   dout        out  WIDTH  head-of-FIFO word
//   dout_valid  out  1      FIFO non-empty
//   dout_ready  in   1      consumer accepts dout when dout_valid=1
//   locked      out  1      receiver is in LOCKED state
//   overflow    out  1      sticky: a completed word was dropped on a full FIFO
module serdes_deser_framed #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter bit               MSB_FIRST  = 1'b0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    input  logic             resync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] SAT_CNT  = CW'(WIDTH);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    bit_cnt;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [NW-1:0]    count;

    logic bit_strobe;
    logic hunt_match;
    logic push;
    logic push_ok;
    logic pop;
    logic fifo_full;

    // Shift register contents including the bit sampled on this edge; both the
    // sync compare and the pushed word use this so the current bit is included.
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST)
            shift_next = {shift_reg[WIDTH-2:0], sin};
        else
            shift_next = {sin, shift_reg[WIDTH-1:1]};
    end

    // resync outranks en, so a bit arriving with resync is never used.
    assign bit_strobe = en && !resync;

    // bit_cnt >= WIDTH-1 before this edge means WIDTH bits have arrived since
    // entering HUNT once the current bit is counted.
    assign hunt_match = (state == ST_HUNT) && bit_strobe &&
                        (bit_cnt >= LAST_BIT) && (shift_next == SYNC_WORD);

    assign push = (state == ST_LOCKED) && bit_strobe && (bit_cnt == LAST_BIT) &&
                  (shift_next != SYNC_WORD);

    assign fifo_full = (count == FULL_CNT);
    assign pop       = dout_valid && dout_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push && (!fifo_full || pop);

    // Framing state machine and shift register.
    always_ff @(posedge clk) begin
        if (rst || resync) begin
            state     <= ST_HUNT;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (en) begin
            shift_reg <= shift_next;
            if (state == ST_HUNT) begin
                if (hunt_match) begin
                    state   <= ST_LOCKED;
                    bit_cnt <= '0;
                end else if (bit_cnt != SAT_CNT) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    // Output FIFO; memory is cleared on reset so an empty FIFO reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift_next;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

    assign dout       = mem[rd_ptr];
    assign dout_valid = (count != '0);
    assign locked     = (state == ST_LOCKED);

endmodule

// File: tb/tb_serdes_deser_framed.sv
// Testbench for serdes_deser_framed: an LSB-first instance and an MSB-first
// instance. Expected words go into per-instance queues; monitors pop and
// compare whenever a word is handed over.
module tb_serdes_deser_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       en = 1'b0, sin = 1'b0, resync = 1'b0, doutReady = 1'b0;
    logic [7:0] dout;
    logic       doutValid, locked, overflow;

    logic       enM = 1'b0, sinM = 1'b0, resyncM = 1'b0, doutReadyM = 1'b1;
    logic [7:0] doutM;
    logic       doutValidM, lockedM, overflowM;

    int total = 0;
    int bad = 0;
    logic [7:0] expQ[$];
    logic [7:0] expQm[$];
    logic [7:0] expMain, expMsb;

    serdes_deser_framed #(.WIDTH(8), .SYNC_WORD(8'hA5), .MSB_FIRST(1'b0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .sin(sin), .resync(resync),
        .dout(dout), .dout_valid(doutValid), .dout_ready(doutReady),
        .locked(locked), .overflow(overflow)
    );

    serdes_deser_framed #(.WIDTH(8), .SYNC_WORD(8'hA5), .MSB_FIRST(1'b1), .FIFO_DEPTH(4)) dutMsb (
        .clk(clk), .rst(rst), .en(enM), .sin(sinM), .resync(resyncM),
        .dout(doutM), .dout_valid(doutValidM), .dout_ready(doutReadyM),
        .locked(lockedM), .overflow(overflowM)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitors: one comparison per handed-over word.
    always @(negedge clk) begin
        if (!rst && doutValid === 1'b1 && doutReady) begin
            if (expQ.size() == 0) begin
                checkOutput("lsb unexpected word", {24'h0, dout}, 32'hFFFFFFFF);
            end else begin
                expMain = expQ.pop_front();
                checkOutput("lsb word", {24'h0, dout}, {24'h0, expMain});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && doutValidM === 1'b1 && doutReadyM) begin
            if (expQm.size() == 0) begin
                checkOutput("msb unexpected word", {24'h0, doutM}, 32'hFFFFFFFF);
            end else begin
                expMsb = expQm.pop_front();
                checkOutput("msb word", {24'h0, doutM}, {24'h0, expMsb});
            end
        end
    end

    task automatic applyStimulus(input logic e, input logic s, input logic r);
        en = e; sin = s; resync = r;
        @(posedge clk); #1;
        en = 1'b0; resync = 1'b0;
    endtask

    task automatic applyStimulusM(input logic e, input logic s, input logic r);
        enM = e; sinM = s; resyncM = r;
        @(posedge clk); #1;
        enM = 1'b0; resyncM = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v, input bit slow);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, v[i], 1'b0);
            if (slow) applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic sendByteM(input logic [7:0] v, input bit msbFirst);
        for (int i = 0; i < 8; i++)
            applyStimulusM(1'b1, msbFirst ? v[7-i] : v[i], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int limit);
        int n = 0;
        while ((expQ.size() + expQm.size()) != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, expQ.size() + expQm.size(), 0);
        idle(1);
    endtask

    initial begin
        #1;
        // Reset state, then a stream of zeros must not lock.
        doReset();
        checkOutput("reset dout", {24'h0, dout}, 0);
        checkOutput("reset valid", {31'h0, doutValid}, 0);
        checkOutput("reset locked", {31'h0, locked}, 0);
        checkOutput("reset overflow", {31'h0, overflow}, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("zeros locked", {31'h0, locked}, 0);
        checkOutput("zeros valid", {31'h0, doutValid}, 0);
        checkOutput("zeros overflow", {31'h0, overflow}, 0);

        // Lock on A5 LSB-first, then deliver 3C as a one-cycle pulse.
        doutReady = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'(8'hA5 >> i), 1'b0);
        checkOutput("locked before 8th", {31'h0, locked}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("locked after 8th", {31'h0, locked}, 1);
        expQ.push_back(8'h3C);
        sendByte(8'h3C, 1'b0);
        checkOutput("3C valid", {31'h0, doutValid}, 1);
        checkOutput("3C dout", {24'h0, dout}, 32'h3C);
        idle(1);
        checkOutput("3C pulse end", {31'h0, doutValid}, 0);

        // Idle-fill sync word in LOCKED is dropped.
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        sendByte(8'h11, 1'b0);
        sendByte(8'hA5, 1'b0);
        sendByte(8'h22, 1'b0);
        waitDrain("idle fill drain", 20);
        checkOutput("idle fill valid", {31'h0, doutValid}, 0);
        checkOutput("still locked", {31'h0, locked}, 1);

        // Overflow: four words fit, the fifth is dropped.
        doReset();
        doutReady = 1'b0;
        sendByte(8'hA5, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            expQ.push_back(8'(i));
            sendByte(8'(i), 1'b0);
        end
        checkOutput("full no overflow", {31'h0, overflow}, 0);
        sendByte(8'h05, 1'b0);
        checkOutput("overflow set", {31'h0, overflow}, 1);
        checkOutput("held head", {24'h0, dout}, 32'h01);
        checkOutput("held valid", {31'h0, doutValid}, 1);
        doutReady = 1'b1;
        waitDrain("overflow drain", 20);
        checkOutput("drained valid", {31'h0, doutValid}, 0);
        checkOutput("overflow sticky", {31'h0, overflow}, 1);

        // MSB-first instance: bit order decides word layout.
        sendByteM(8'hA5, 1'b1);
        checkOutput("msb locked", {31'h0, lockedM}, 1);
        expQm.push_back(8'h81);
        sendByteM(8'h81, 1'b1);
        expQm.push_back(8'h12);
        sendByteM(8'h12, 1'b1);
        expQm.push_back(8'h48);
        sendByteM(8'h12, 1'b0);
        waitDrain("msb drain", 20);
        applyStimulusM(1'b0, 1'b0, 1'b1);
        checkOutput("msb resync", {31'h0, lockedM}, 0);
        sendByteM(8'h3C, 1'b0);
        sendByteM(8'h3C, 1'b0);
        checkOutput("msb no lock", {31'h0, lockedM}, 0);

        // resync keeps the FIFO, loses the partial word; slow en afterwards.
        doReset();
        doutReady = 1'b0;
        sendByte(8'hA5, 1'b0);
        expQ.push_back(8'h5A);
        sendByte(8'h5A, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("resync locked", {31'h0, locked}, 0);
        checkOutput("resync valid", {31'h0, doutValid}, 1);
        checkOutput("resync dout", {24'h0, dout}, 32'h5A);
        checkOutput("resync overflow", {31'h0, overflow}, 0);
        doutReady = 1'b1;
        waitDrain("resync drain", 20);
        sendByte(8'hA5, 1'b1);
        checkOutput("slow relock", {31'h0, locked}, 1);
        expQ.push_back(8'h77);
        sendByte(8'h77, 1'b1);
        waitDrain("slow drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
